mem_access: RTL and testbench

- Memory-access stage of the RV32 pipeline, directly upstream of the write-back stage.
- Takes the decoded instruction and execute-stage result and performs the load or store over a req/ack data-memory port.
- Produces the write-back value, passes the instruction and jump flag forward, and signals completion with `completed`.
- Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_access_load_align.sv | 36 +++
 rtl/mem_access.sv | 119 +++++++++++
 tb/tb_mem_access.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the RV32 memory-access stage.
// Holds the decoded-instruction struct, funct3 codes and the alignment rule.
package mem_access_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       writes_to_reg;
    logic       writes_to_freg_as_rv32f;
  } instructions;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // size is funct3[1:0]: 0 byte, 1 half, anything else treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module load_align
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[7:0];
    case (off)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    half_c = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value_c = rdata;
    case (funct3)
      F3_LB:   value_c = {{24{byte_c[7]}}, byte_c};
      F3_LBU:  value_c = {24'd0, byte_c};
      F3_LH:   value_c = {{16{half_c[15]}}, half_c};
      F3_LHU:  value_c = {16'd0, half_c};
      default: value_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32 memory-access stage: issues one load/store over a req/ack port,
// or passes ALU results straight through to write-back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enabled,
  input  instructions           instr,
  input  logic [XLEN-1:0]       ex_result,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic                  is_jump_chosen,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata,
  output instructions           instr_n,
  output logic [XLEN-1:0]       data,
  output logic                  is_jump_chosen_n,
  output logic                  misaligned,
  output logic                  completed
);

  state_t          state;
  logic [1:0]      off_q;
  logic [3:0]      strb_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] load_c;

  // Store lane replication; byte enables select which copy memory keeps.
  always_comb begin
    strb_c  = 4'b0000;
    wdata_c = '0;
    if (instr.is_store) begin
      case (instr.funct3)
        F3_SB: begin
          strb_c  = 4'b0001 << ex_result[1:0];
          wdata_c = {4{rs2_data[7:0]}};
        end
        F3_SH: begin
          strb_c  = 4'b0011 << ex_result[1:0];
          wdata_c = {2{rs2_data[15:0]}};
        end
        default: begin
          strb_c  = 4'b1111;
          wdata_c = rs2_data;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata   (mem_rdata),
    .off     (off_q),
    .funct3  (instr_n.funct3),
    .value_c (load_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      off_q            <= 2'b00;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wstrb        <= 4'b0000;
      mem_wdata        <= '0;
      instr_n          <= '0;
      data             <= '0;
      is_jump_chosen_n <= 1'b0;
      misaligned       <= 1'b0;
      completed        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enabled) begin
            instr_n          <= instr;
            is_jump_chosen_n <= is_jump_chosen;
            off_q            <= ex_result[1:0];
            if (!instr.is_load && !instr.is_store) begin
              data       <= ex_result;
              misaligned <= 1'b0;
              completed  <= 1'b1;
            end else if (is_misaligned(instr.funct3[1:0], ex_result[1:0])) begin
              data       <= '0;
              misaligned <= 1'b1;
              completed  <= 1'b1;
            end else begin
              state      <= REQ;
              mem_req    <= 1'b1;
              mem_we     <= instr.is_store;
              mem_addr   <= ADDR_WIDTH'({ex_result[XLEN-1:2], 2'b00});
              mem_wstrb  <= strb_c;
              mem_wdata  <= wdata_c;
              misaligned <= 1'b0;
              completed  <= 1'b0;
            end
          end
        end
        REQ: begin
          // Request fields stay frozen until memory acknowledges.
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            completed <= 1'b1;
            data      <= instr_n.is_load ? load_c : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  instructions instr = '0;
  logic [31:0] ex_result = '0;
  logic [31:0] rs2_data = '0;
  logic        is_jump_chosen = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  instructions instr_n;
  logic [31:0] data;
  logic        is_jump_chosen_n, misaligned, completed;

  int n_pass = 0;
  int n_total = 0;

  mem_access #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .instr(instr),
    .ex_result(ex_result), .rs2_data(rs2_data), .is_jump_chosen(is_jump_chosen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_n(instr_n), .data(data), .is_jump_chosen_n(is_jump_chosen_n),
    .misaligned(misaligned), .completed(completed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] ex;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: derived from access size/offset arithmetic.
  function automatic exp_t model(input instructions ins, input logic [31:0] ex,
                                 input logic [31:0] rs2, input logic [31:0] rdata);
    exp_t        e;
    int          n;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    e   = '0;
    off = int'(ex[1:0]);
    n   = 1 << ins.funct3[1:0];
    if (!ins.is_load && !ins.is_store) begin
      e.data = ex;
      return e;
    end
    if (off % n != 0) begin
      e.mis = 1'b1;
      return e;
    end
    e.req  = 1'b1;
    e.we   = ins.is_store;
    e.addr = ex - 32'(off);
    if (ins.is_store) begin
      e.wstrb = 4'(((1 << n) - 1) << off);
      if (n == 1)      e.wdata = 32'(rs2[7:0]) * 32'h0101_0101;
      else if (n == 2) e.wdata = 32'(rs2[15:0]) * 32'h0001_0001;
      else             e.wdata = rs2;
    end else begin
      v    = rdata >> (8 * off);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v    = v & mask;
      if (!ins.funct3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      e.data = v;
    end
    return e;
  endfunction

  // Starts at posedge+1; returns at posedge+1 after the operation completes.
  task automatic run_op(input string name, input instructions ins, input logic [31:0] ex,
                        input logic [31:0] rs2, input logic jmp, input logic [31:0] rdata,
                        input int delay, input exp_t e);
    instr = ins; ex_result = ex; rs2_data = rs2; is_jump_chosen = jmp; enabled = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    instr = '0; ex_result = $urandom; rs2_data = $urandom; is_jump_chosen = ~jmp;
    if (!e.req) begin
      check({name, ".req"}, 32'(mem_req), 32'd0);
      check({name, ".completed"}, 32'(completed), 32'd1);
      check({name, ".data"}, data, e.data);
      check({name, ".misaligned"}, 32'(misaligned), 32'(e.mis));
    end else begin
      check({name, ".req"}, 32'(mem_req), 32'd1);
      check({name, ".completed0"}, 32'(completed), 32'd0);
      check({name, ".addr"}, mem_addr, e.addr);
      check({name, ".we"}, 32'(mem_we), 32'(e.we));
      check({name, ".wstrb"}, 32'(mem_wstrb), 32'(e.wstrb));
      if (e.we) check({name, ".wdata"}, mem_wdata, e.wdata);
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
        check({name, ".req_held"}, 32'(mem_req), 32'd1);
        check({name, ".addr_held"}, mem_addr, e.addr);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      check({name, ".req_drop"}, 32'(mem_req), 32'd0);
      check({name, ".completed"}, 32'(completed), 32'd1);
      check({name, ".data"}, data, e.data);
      check({name, ".misaligned"}, 32'(misaligned), 32'd0);
    end
    check({name, ".instr_n"}, 32'(instr_n), 32'(ins));
    check({name, ".jump_n"}, 32'(is_jump_chosen_n), 32'(jmp));
  endtask

  function automatic instructions mk(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [4:0] rd);
    instructions ins;
    ins = '0;
    ins.is_load = ld; ins.is_store = st; ins.funct3 = f3; ins.rd = rd;
    ins.writes_to_reg = ld | (~ld & ~st);
    return ins;
  endfunction

  vec_t        tbl [13];
  instructions ins;
  instructions first_ins;
  exp_t        e;
  logic [31:0] saved;
  logic [2:0]  ld_f3 [5];
  logic [2:0]  st_f3 [3];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 0,
                '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b0}};
    tbl[1]  = '{1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 32'h8000_0000, 2,
                '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0}};
    tbl[2]  = '{1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 32'h8000_0000, 2,
                '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 1'b0}};
    tbl[3]  = '{1'b0, 1'b1, F3_SH, 32'h202, 32'hDEAD_BEEF, 32'h0, 0,
                '{1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0}};
    tbl[4]  = '{1'b1, 1'b0, F3_LW, 32'h105, 32'h0, 32'h0, 0,
                '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1}};
    tbl[5]  = '{1'b1, 1'b0, F3_LW, 32'h108, 32'h0, 32'h1234_5678, 1,
                '{1'b1, 1'b0, 32'h108, 4'h0, 32'h0, 32'h1234_5678, 1'b0}};
    tbl[6]  = '{1'b1, 1'b0, F3_LH, 32'h102, 32'h0, 32'h8001_7FFF, 0,
                '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0}};
    tbl[7]  = '{1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 32'h8001_7FFF, 3,
                '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_8001, 1'b0}};
    tbl[8]  = '{1'b0, 1'b1, F3_SB, 32'h301, 32'h0000_00A5, 32'h0, 1,
                '{1'b1, 1'b1, 32'h300, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0}};
    tbl[9]  = '{1'b0, 1'b1, F3_SW, 32'h400, 32'hCAFE_F00D, 32'h0, 0,
                '{1'b1, 1'b1, 32'h400, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0}};
    tbl[10] = '{1'b0, 1'b1, F3_SH, 32'h203, 32'h1111_2222, 32'h0, 0,
                '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1}};
    tbl[11] = '{1'b1, 1'b0, F3_LB, 32'h101, 32'h0, 32'h0000_7F00, 0,
                '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 32'h0000_007F, 1'b0}};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 32'h105, 32'h0, 32'h0, 0,
                '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0105, 1'b0}};
    ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    st_f3 = '{F3_SB, F3_SH, F3_SW};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst.completed", 32'(completed), 32'd0);
    check("rst.data", data, 32'd0);
    check("rst.misaligned", 32'(misaligned), 32'd0);
    check("rst.instr_n", 32'(instr_n), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // mem_ack while idle has no effect
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("idle_ack.data", data, 32'd0);
    check("idle_ack.completed", 32'(completed), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), mk(tbl[i].ld, tbl[i].st, tbl[i].f3, 5'(i + 1)),
             tbl[i].ex, tbl[i].rs2, 1'(i), tbl[i].rdata, tbl[i].delay, tbl[i].e);
    end

    // enabled during REQ is ignored; result follows the first instruction
    first_ins = mk(1'b1, 1'b0, F3_LB, 5'd3);
    instr = first_ins; ex_result = 32'h103; is_jump_chosen = 1'b1; enabled = 1'b1;
    @(posedge clk); #1;
    instr = mk(1'b0, 1'b1, F3_SW, 5'd9); ex_result = 32'h600; rs2_data = 32'h5555_AAAA;
    is_jump_chosen = 1'b0;
    @(posedge clk); #1;
    enabled = 1'b0;
    check("busy.req", 32'(mem_req), 32'd1);
    check("busy.addr", mem_addr, 32'h100);
    check("busy.we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h7F00_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("busy.data", data, 32'h0000_007F);
    check("busy.instr_n", 32'(instr_n), 32'(first_ins));
    check("busy.jump_n", 32'(is_jump_chosen_n), 32'd1);
    check("busy.completed", 32'(completed), 32'd1);
    check("busy.state_idle_req", 32'(mem_req), 32'd0);

    // mem_ack in IDLE after completion leaves outputs alone
    saved = data;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack.data", data, saved);
    check("late_ack.completed", 32'(completed), 32'd1);

    // Async reset during REQ, then a stray ack after release
    instr = mk(1'b1, 1'b0, F3_LW, 5'd7); ex_result = 32'h500; enabled = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    check("rstreq.req", 32'(mem_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rstreq.req_async", 32'(mem_req), 32'd0);
    check("rstreq.completed", 32'(completed), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hABCD_1234;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("rstreq.ack_data", data, 32'd0);
    check("rstreq.ack_completed", 32'(completed), 32'd0);
    check("rstreq.ack_req", 32'(mem_req), 32'd0);
    check("rstreq.instr_n", 32'(instr_n), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      int k;
      logic [31:0] ex, rs2, rd;
      k = int'($urandom_range(0, 8));
      if (k < 5)      ins = mk(1'b1, 1'b0, ld_f3[k], 5'($urandom));
      else if (k < 8) ins = mk(1'b0, 1'b1, st_f3[k-5], 5'($urandom));
      else            ins = mk(1'b0, 1'b0, 3'($urandom), 5'($urandom));
      ex  = $urandom;
      rs2 = $urandom;
      rd  = $urandom;
      e   = model(ins, ex, rs2, rd);
      run_op($sformatf("rnd%0d", i), ins, ex, rs2, 1'($urandom), rd,
             int'($urandom_range(0, 3)), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
